// File: rtl/training_sequencer.sv
// rtl/training_sequencer.sv - perceptron training sequencer over a small sample memory
//
// Replays DEPTH stored samples to a perceptron for EPOCHS epochs (forward
// argument/result, backward error/feedback), then runs one evaluation pass
// with learning disabled and reports {epochs_run, mismatches}.
//
// Optional feature: define TRAINING_SEQUENCER_EARLY_STOP_EN to end training
// after the first epoch in which every error is zero.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   smp_stb/smp_rdy/smp_dat     sample write {target, args}
//   run_stb/run_rdy             start a run (accepted only when idle)
//   sts_stb/sts_rdy/sts_dat     run status {epochs_run[15:8], mismatches[7:0]}
//   en                          perceptron learning enable
//   arg_stb/arg_rdy/arg_dat     forward arguments to perceptron
//   res_stb/res_rdy/res_dat     forward result from perceptron
//   err_stb/err_rdy/err_dat     signed backward error to perceptron
//   fbk_stb/fbk_rdy/fbk_dat     backward feedback from perceptron (discarded)

module training_sequencer #(
    parameter int N      = 2,
    parameter int W      = 8,
    parameter int DEPTH  = 4,
    parameter int EPOCHS = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             smp_stb,
    output logic             smp_rdy,
    input  logic [N*W+W-1:0] smp_dat,
    input  logic             run_stb,
    output logic             run_rdy,
    output logic             sts_stb,
    input  logic             sts_rdy,
    output logic [15:0]      sts_dat,
    output logic             en,
    output logic             arg_stb,
    input  logic             arg_rdy,
    output logic [N*W-1:0]   arg_dat,
    input  logic             res_stb,
    output logic             res_rdy,
    input  logic [W-1:0]     res_dat,
    output logic             err_stb,
    input  logic             err_rdy,
    output logic [2*W-1:0]   err_dat,
    input  logic             fbk_stb,
    output logic             fbk_rdy,
    input  logic [N*2*W-1:0] fbk_dat
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int SW = N*W + W;
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_ARG, S_RES, S_ERR, S_FBK, S_EVAL_ARG, S_EVAL_RES, S_STATUS
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [7:0]      epoch_q, epoch_d;
    logic [7:0]      mis_q, mis_d;
    logic [2*W-1:0]  err_q, err_d;
    logic            en_q, en_d;
    logic            smp_rdy_q, smp_rdy_d;
    logic            run_rdy_q, run_rdy_d;
    logic            arg_stb_q, arg_stb_d;
    logic            res_rdy_q, res_rdy_d;
    logic            err_stb_q, err_stb_d;
    logic            fbk_rdy_q, fbk_rdy_d;
    logic            sts_stb_q, sts_stb_d;
`ifdef TRAINING_SEQUENCER_EARLY_STOP_EN
    logic            clean_q, clean_d;
`endif

    // Sample memory has no reset so samples survive an abandoned run.
    logic [SW-1:0]   mem_q [DEPTH];
    logic            mem_we;

    logic [SW-1:0]   cur_smp;
    logic [W-1:0]    cur_tgt;
    logic [2*W-1:0]  err_calc;
    logic [AW-1:0]   idx_next;
    logic [7:0]      epoch_inc;
    logic            stop_early;
    logic            unused_fbk;

    assign cur_smp   = mem_q[idx_q];
    assign cur_tgt   = cur_smp[SW-1 -: W];
    // Zero-extended subtraction in 2W bits equals the signed (W+1)-bit difference.
    assign err_calc  = {{W{1'b0}}, cur_tgt} - {{W{1'b0}}, res_dat};
    assign idx_next  = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
    assign epoch_inc = epoch_q + 8'd1;
    assign unused_fbk = ^fbk_dat;

`ifdef TRAINING_SEQUENCER_EARLY_STOP_EN
    assign stop_early = clean_q;
`else
    assign stop_early = 1'b0;
`endif

    assign smp_rdy = smp_rdy_q;
    assign run_rdy = run_rdy_q;
    assign en      = en_q;
    assign arg_stb = arg_stb_q;
    assign arg_dat = cur_smp[N*W-1:0];
    assign res_rdy = res_rdy_q;
    assign err_stb = err_stb_q;
    assign err_dat = err_q;
    assign fbk_rdy = fbk_rdy_q;
    assign sts_stb = sts_stb_q;
    assign sts_dat = {epoch_q, mis_q};

    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        idx_d     = idx_q;
        epoch_d   = epoch_q;
        mis_d     = mis_q;
        err_d     = err_q;
        en_d      = en_q;
        smp_rdy_d = smp_rdy_q;
        run_rdy_d = run_rdy_q;
        arg_stb_d = arg_stb_q;
        res_rdy_d = res_rdy_q;
        err_stb_d = err_stb_q;
        fbk_rdy_d = fbk_rdy_q;
        sts_stb_d = sts_stb_q;
        mem_we    = 1'b0;
`ifdef TRAINING_SEQUENCER_EARLY_STOP_EN
        clean_d   = clean_q;
`endif
        case (state_q)
            S_IDLE: begin
                // The write lands on the same edge as the run start, so the
                // first argument read already sees it.
                if (smp_stb && smp_rdy_q) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
                end
                if (run_stb && run_rdy_q) begin
                    idx_d     = '0;
                    epoch_d   = '0;
                    mis_d     = '0;
                    en_d      = 1'b1;
                    smp_rdy_d = 1'b0;
                    run_rdy_d = 1'b0;
                    arg_stb_d = 1'b1;
                    state_d   = S_ARG;
`ifdef TRAINING_SEQUENCER_EARLY_STOP_EN
                    clean_d   = 1'b1;
`endif
                end
            end
            S_ARG, S_EVAL_ARG: begin
                if (arg_rdy) begin
                    arg_stb_d = 1'b0;
                    res_rdy_d = 1'b1;
                    state_d   = (state_q == S_ARG) ? S_RES : S_EVAL_RES;
                end
            end
            S_RES: begin
                if (res_stb) begin
                    res_rdy_d = 1'b0;
                    err_d     = err_calc;
                    err_stb_d = 1'b1;
                    state_d   = S_ERR;
                end
            end
            S_ERR: begin
                if (err_rdy) begin
                    err_stb_d = 1'b0;
                    fbk_rdy_d = 1'b1;
                    state_d   = S_FBK;
`ifdef TRAINING_SEQUENCER_EARLY_STOP_EN
                    if (err_q != '0) clean_d = 1'b0;
`endif
                end
            end
            S_FBK: begin
                if (fbk_stb) begin
                    fbk_rdy_d = 1'b0;
                    arg_stb_d = 1'b1;
                    idx_d     = idx_next;
                    state_d   = S_ARG;
                    if (idx_q == LAST_IDX) begin
                        epoch_d = epoch_inc;
                        if (epoch_inc == 8'(EPOCHS) || stop_early) begin
                            en_d    = 1'b0;
                            state_d = S_EVAL_ARG;
                        end
`ifdef TRAINING_SEQUENCER_EARLY_STOP_EN
                        clean_d = 1'b1;
`endif
                    end
                end
            end
            S_EVAL_RES: begin
                if (res_stb) begin
                    res_rdy_d = 1'b0;
                    idx_d     = idx_next;
                    if (err_calc != '0 && mis_q != 8'hff) mis_d = mis_q + 8'd1;
                    if (idx_q == LAST_IDX) begin
                        sts_stb_d = 1'b1;
                        state_d   = S_STATUS;
                    end else begin
                        arg_stb_d = 1'b1;
                        state_d   = S_EVAL_ARG;
                    end
                end
            end
            S_STATUS: begin
                if (sts_rdy) begin
                    sts_stb_d = 1'b0;
                    smp_rdy_d = 1'b1;
                    run_rdy_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_ptr_q  <= '0;
            idx_q     <= '0;
            epoch_q   <= '0;
            mis_q     <= '0;
            err_q     <= '0;
            en_q      <= 1'b0;
            smp_rdy_q <= 1'b1;
            run_rdy_q <= 1'b1;
            arg_stb_q <= 1'b0;
            res_rdy_q <= 1'b0;
            err_stb_q <= 1'b0;
            fbk_rdy_q <= 1'b0;
            sts_stb_q <= 1'b0;
`ifdef TRAINING_SEQUENCER_EARLY_STOP_EN
            clean_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            idx_q     <= idx_d;
            epoch_q   <= epoch_d;
            mis_q     <= mis_d;
            err_q     <= err_d;
            en_q      <= en_d;
            smp_rdy_q <= smp_rdy_d;
            run_rdy_q <= run_rdy_d;
            arg_stb_q <= arg_stb_d;
            res_rdy_q <= res_rdy_d;
            err_stb_q <= err_stb_d;
            fbk_rdy_q <= fbk_rdy_d;
            sts_stb_q <= sts_stb_d;
`ifdef TRAINING_SEQUENCER_EARLY_STOP_EN
            clean_q   <= clean_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[wr_ptr_q] <= smp_dat;
    end

endmodule
